// File: rtl/neuron_pkg.sv
// Shared widths, types and default fixed weights/thresholds for the neuron tile.
package neuron_pkg;

  localparam int WEIGHT_W = 4;
  localparam int SUM_W    = 10;
  localparam int IN_W     = 4;

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic signed [SUM_W-1:0]    sum_t;

  // Hidden layer: n1 fires on a large total, n2 fires when x0 exceeds x1.
  localparam weight_t W10 = 4'sd1;
  localparam weight_t W11 = 4'sd1;
  localparam sum_t    T1  = 10'sd4;
  localparam weight_t W20 = 4'sd1;
  localparam weight_t W21 = -4'sd1;
  localparam sum_t    T2  = 10'sd1;

  // Output layer: with these values n3 is the AND of n1 and n2.
  localparam weight_t W30 = 4'sd1;
  localparam weight_t W31 = 4'sd1;
  localparam sum_t    T3  = 10'sd2;

  // Inputs are magnitudes, so they are zero-extended before entering the signed datapath.
  function automatic sum_t widen_input(logic [IN_W-1:0] v);
    return sum_t'(signed'({1'b0, v}));
  endfunction

endpackage

// File: rtl/neuron_net_if.sv
// Sample inputs and spike outputs of the neuron tile, as seen by the pad wrapper.
interface neuron_net_if;
  import neuron_pkg::*;

  logic [IN_W-1:0] x0;
  logic [IN_W-1:0] x1;
  logic            n1_out;
  logic            n2_out;
  logic            n3_out;
  logic            valid;

  modport master (
    output x0, x1,
    input  n1_out, n2_out, n3_out, valid
  );

  modport slave (
    input  x0, x1,
    output n1_out, n2_out, n3_out, valid
  );

endinterface

// File: rtl/neuron_unit.sv
// One threshold neuron: two weighted unsigned inputs, signed sum, fire on sum >= T.
module neuron_unit
  import neuron_pkg::*;
#(
  parameter weight_t WA = W10,
  parameter weight_t WB = W11,
  parameter sum_t    T  = T1
) (
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic            spike
);

  sum_t sum;

  // NOTE: both outputs are assigned on every pass through always_comb, so no latch can be inferred.
  always_comb begin
    sum   = widen_input(a) * sum_t'(WA) + widen_input(b) * sum_t'(WB);
    spike = (sum >= T);
  end

endmodule

// File: rtl/neuron_net.sv
// Two-layer fixed-weight threshold network with a two-stage registered pipeline.
module neuron_net
  import neuron_pkg::*;
#(
  parameter weight_t P_W10 = W10,
  parameter weight_t P_W11 = W11,
  parameter sum_t    P_T1  = T1,
  parameter weight_t P_W20 = W20,
  parameter weight_t P_W21 = W21,
  parameter sum_t    P_T2  = T2,
  parameter weight_t P_W30 = W30,
  parameter weight_t P_W31 = W31,
  parameter sum_t    P_T3  = T3
) (
  input  logic        clk,
  input  logic        rst,
  neuron_net_if.slave bus
);

  logic            n1_spike;
  logic            n2_spike;
  logic            n3_spike;
  logic            n1_q;
  logic            n2_q;
  logic            n3_q;
  logic [1:0]      valid_sr;
  logic [IN_W-1:0] h1_ext;
  logic [IN_W-1:0] h2_ext;

  neuron_unit #(.WA(P_W10), .WB(P_W11), .T(P_T1)) u_n1 (
    .a     (bus.x0),
    .b     (bus.x1),
    .spike (n1_spike)
  );

  neuron_unit #(.WA(P_W20), .WB(P_W21), .T(P_T2)) u_n2 (
    .a     (bus.x0),
    .b     (bus.x1),
    .spike (n2_spike)
  );

  // Hidden spikes feed the output neuron as 0/1 magnitudes.
  assign h1_ext = {{(IN_W-1){1'b0}}, n1_q};
  assign h2_ext = {{(IN_W-1){1'b0}}, n2_q};

  neuron_unit #(.WA(P_W30), .WB(P_W31), .T(P_T3)) u_n3 (
    .a     (h1_ext),
    .b     (h2_ext),
    .spike (n3_spike)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make stage 2 see the pre-edge hidden spikes, giving the 2-clock latency.
    if (rst) begin
      n1_q     <= 1'b0;
      n2_q     <= 1'b0;
      n3_q     <= 1'b0;
      valid_sr <= 2'b00;
    end else begin
      n1_q     <= n1_spike;
      n2_q     <= n2_spike;
      n3_q     <= n3_spike;
      valid_sr <= {valid_sr[0], 1'b1};
    end
  end

  assign bus.n1_out = n1_q;
  assign bus.n2_out = n2_q;
  assign bus.n3_out = n3_q;
  assign bus.valid  = valid_sr[1];

endmodule

// File: tb/tb_neuron_net.sv
// Scoreboard bench for neuron_net: driver pushes expected outputs, monitor pops and compares after each edge.
module tb_neuron_net;
  import neuron_pkg::*;

  typedef struct packed {
    bit n1;
    bit n2;
    bit n3;
    bit valid;
  } exp_t;

  logic clk;
  logic rst;
  neuron_net_if bus ();

  neuron_net dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: inputs seen at the previous edge and edges since reset.
  int prev_a   = 0;
  int prev_b   = 0;
  bit prev_rst = 1'b1;
  int since    = 0;

  // Behavioural network: n1 = big total, n2 = x0 above x1, n3 = both hidden neurons firing.
  function automatic bit ref_n1(int a, int b);
    return (a + b) >= 4;
  endfunction

  function automatic bit ref_n2(int a, int b);
    return (a - b) >= 1;
  endfunction

  function automatic bit ref_n3(bit h1, bit h2);
    return (int'(h1) + int'(h2)) >= 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one sample for the coming edge and push what the outputs must be just after it.
  task automatic step(input int a, input int b, input bit r, input bit glitch);
    exp_t e;
    bit   h1;
    bit   h2;
    @(negedge clk);
    bus.x0 = 4'(a);
    bus.x1 = 4'(b);
    rst    = r;
    if (r) begin
      e     = '0;
      since = 0;
    end else begin
      h1      = prev_rst ? 1'b0 : ref_n1(prev_a, prev_b);
      h2      = prev_rst ? 1'b0 : ref_n2(prev_a, prev_b);
      e.n1    = ref_n1(a, b);
      e.n2    = ref_n2(a, b);
      e.n3    = ref_n3(h1, h2);
      since   = (since < 2) ? since + 1 : 2;
      e.valid = (since >= 2);
    end
    prev_a   = a;
    prev_b   = b;
    prev_rst = r;
    exp_q.push_back(e);
    if (glitch) begin
      #1;
      bus.x0 = ~bus.x0;
      bus.x1 = ~bus.x1;
      #1;
      bus.x0 = 4'(a);
      bus.x1 = 4'(b);
    end
  endtask

  // Monitor: outputs are registered, so compare shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("n1_out", 32'(bus.n1_out), 32'(e.n1));
        check("n2_out", 32'(bus.n2_out), 32'(e.n2));
        check("n3_out", 32'(bus.n3_out), 32'(e.n3));
        check("valid",  32'(bus.valid),  32'(e.valid));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    bus.x0 = '0;
    bus.x1 = '0;

    // Reset held two clocks, then release; valid rises on the second edge after release.
    step(9, 2, 1'b1, 1'b0);
    step(9, 2, 1'b1, 1'b0);
    step(9, 2, 1'b0, 1'b0);
    step(9, 2, 1'b0, 1'b0);

    // Directed patterns, each held two clocks, including the boundary corners.
    step(2, 1, 1'b0, 1'b0);   step(2, 1, 1'b0, 1'b0);
    step(4, 3, 1'b0, 1'b1);   step(4, 3, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);   step(0, 0, 1'b0, 1'b0);
    step(15, 15, 1'b0, 1'b0); step(15, 15, 1'b0, 1'b0);
    step(15, 0, 1'b0, 1'b1);  step(15, 0, 1'b0, 1'b0);
    step(3, 3, 1'b0, 1'b0);   step(3, 3, 1'b0, 1'b0);

    // Full sweep, one pair per clock, with a reset mid-stream and between-edge glitches.
    for (int i = 0; i < 256; i++) begin
      step(i / 16, i % 16, (i == 128), (i % 7 == 3));
    end

    // Random stream with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
